// File: rtl/wb_ddr_arbiter.sv
// wb_ddr_arbiter: round-robin arbiter sharing one DDR Wishbone slave between
// the LM32 I-bus (m0) and D-bus (m1). Define WB_ARB_TIMEOUT_EN for a stall watchdog.
module wb_ddr_arbiter #(
  parameter int ADR_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [3:0]       m0_sel,
  input  logic [31:0]      m0_dat_w,
  output logic [31:0]      m0_dat_r,
  output logic             m0_ack,
  output logic             m0_err,
  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [3:0]       m1_sel,
  input  logic [31:0]      m1_dat_w,
  output logic [31:0]      m1_dat_r,
  output logic             m1_ack,
  output logic             m1_err,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [3:0]       s_sel,
  output logic [31:0]      s_dat_w,
  input  logic [31:0]      s_dat_r,
  input  logic             s_ack,
  input  logic             s_err,
  output logic [1:0]       gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_gnt;
  logic   w_mcyc;
  logic   w_mstb;
  logic   w_rel;
  logic   w_to;

  if (TIMEOUT < 2) begin : g_to_chk
    $error("wb_ddr_arbiter: TIMEOUT must be >= 2");
  end

  always_comb begin
    w_mcyc = 1'b0;
    w_mstb = 1'b0;
    case (r_state)
      GNT0: begin
        w_mcyc = m0_cyc;
        w_mstb = m0_stb;
      end
      GNT1: begin
        w_mcyc = m1_cyc;
        w_mstb = m1_stb;
      end
      default: ;
    endcase
  end

  assign w_rel = ~w_mcyc | w_to;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic          w_enter;

  assign w_enter = (w_next != r_state) && (w_next != IDLE);
  assign w_to    = (r_state != IDLE) && (r_cnt == CW'(TIMEOUT - 1));

  // Counts only stalled strobes; any slave response restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_enter) begin
      r_cnt <= '0;
    end else if (r_state != IDLE) begin
      if (s_ack | s_err | w_to) r_cnt <= '0;
      else if (w_mcyc & w_mstb) r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == GNT0) r_last_gnt <= 1'b0;
      else if (w_next == GNT1) r_last_gnt <= 1'b1;
    end
  end

  // Release hands over directly to a waiting master, no idle bubble.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc & m1_cyc) w_next = r_last_gnt ? GNT0 : GNT1;
        else if (m0_cyc)     w_next = GNT0;
        else if (m1_cyc)     w_next = GNT1;
      end
      GNT0: if (w_rel) w_next = m1_cyc ? GNT1 : IDLE;
      GNT1: if (w_rel) w_next = m0_cyc ? GNT0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_cyc   = w_mcyc & ~w_to;
    s_stb   = w_mstb & ~w_to;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    gnt     = 2'b00;
    case (r_state)
      GNT0: begin
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_sel   = m0_sel;
        s_dat_w = m0_dat_w;
        m0_ack  = s_ack;
        m0_err  = s_err | w_to;
        gnt     = 2'b01;
      end
      GNT1: begin
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_sel   = m1_sel;
        s_dat_w = m1_dat_w;
        m1_ack  = s_ack;
        m1_err  = s_err | w_to;
        gnt     = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; ack tells each master when it is valid.
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// tb_wb_ddr_arbiter: vector table, corner sequences and a randomized
// run against a grant-owner reference model.
module tb_wb_ddr_arbiter;
  localparam int ADR_W = 32;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [ADR_W-1:0] m0_adr;
  logic [3:0]       m0_sel;
  logic [31:0]      m0_dat_w, m0_dat_r;
  logic             m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [ADR_W-1:0] m1_adr;
  logic [3:0]       m1_sel;
  logic [31:0]      m1_dat_w, m1_dat_r;
  logic             s_cyc, s_stb, s_we, s_ack, s_err;
  logic [ADR_W-1:0] s_adr;
  logic [3:0]       s_sel;
  logic [31:0]      s_dat_w, s_dat_r;
  logic [1:0]       gnt;

  wb_ddr_arbiter #(.ADR_W(ADR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_sel(s_sel), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
    .s_ack(s_ack), .s_err(s_err), .gnt(gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic c0, s0, c1, s1, ack, err;
    logic [1:0] g;
    logic scyc, sstb, a0, e0, a1, e1;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // reference model state
  int   own, mlast, mcnt, nxt;
  logic mc[2];
  logic ms[2];
  logic e_to, e_scyc, e_sstb, e_a0, e_e0, e_a1, e_e1;
  logic [1:0] e_gnt;
  logic [ADR_W+36:0] e_bus;

  int   acks[2];
  bit   drop[2];
  int   done, w;

  function automatic vec_t mk(input logic [5:0] i, input logic [1:0] g,
                              input logic [5:0] o);
    vec_t v;
    {v.c0, v.s0, v.c1, v.s1, v.ack, v.err} = i;
    v.g = g;
    {v.scyc, v.sstb, v.a0, v.e0, v.a1, v.e1} = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c0, s0, c1, s1, ack, err);
    m0_cyc = c0; m0_stb = s0;
    m1_cyc = c1; m1_stb = s1;
    s_ack  = ack; s_err = err;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic fixed_masters();
    m0_we = 1'b0; m0_adr = 32'h100; m0_sel = 4'h3; m0_dat_w = 32'hA0A0_0000;
    m1_we = 1'b1; m1_adr = 32'h200; m1_sel = 4'hC; m1_dat_w = 32'hB1B1_1111;
  endtask

  function automatic logic [ADR_W+36:0] bus_of(input logic [1:0] g);
    if (g == 2'b01) return {m0_we, m0_adr, m0_sel, m0_dat_w};
    if (g == 2'b10) return {m1_we, m1_adr, m1_sel, m1_dat_w};
    return '0;
  endfunction

  initial begin
    // cycle-by-cycle from reset: {c0 s0 c1 s1 ack err}, gnt, {scyc sstb a0 e0 a1 e1}
    tbl.push_back(mk(6'b000000, 2'b00, 6'b000000));
    tbl.push_back(mk(6'b110000, 2'b00, 6'b000000));
    tbl.push_back(mk(6'b110000, 2'b01, 6'b110000));
    tbl.push_back(mk(6'b110000, 2'b01, 6'b110000));
    tbl.push_back(mk(6'b110010, 2'b01, 6'b111000));
    tbl.push_back(mk(6'b000000, 2'b01, 6'b000000));
    tbl.push_back(mk(6'b000010, 2'b00, 6'b000000));
    tbl.push_back(mk(6'b111100, 2'b00, 6'b000000));
    tbl.push_back(mk(6'b111100, 2'b10, 6'b110000));
    tbl.push_back(mk(6'b111101, 2'b10, 6'b110001));
    tbl.push_back(mk(6'b110000, 2'b10, 6'b000000));
    tbl.push_back(mk(6'b110010, 2'b01, 6'b111000));
    tbl.push_back(mk(6'b100000, 2'b01, 6'b100000));
    tbl.push_back(mk(6'b110001, 2'b01, 6'b110100));
    tbl.push_back(mk(6'b001100, 2'b01, 6'b000000));
    tbl.push_back(mk(6'b001100, 2'b10, 6'b110000));
    tbl.push_back(mk(6'b001110, 2'b10, 6'b110010));
    tbl.push_back(mk(6'b000000, 2'b10, 6'b000000));
    tbl.push_back(mk(6'b000000, 2'b00, 6'b000000));
    tbl.push_back(mk(6'b110000, 2'b00, 6'b000000));
    tbl.push_back(mk(6'b111100, 2'b01, 6'b110000));
    tbl.push_back(mk(6'b110000, 2'b01, 6'b110000));
    tbl.push_back(mk(6'b000000, 2'b01, 6'b000000));
    tbl.push_back(mk(6'b000000, 2'b00, 6'b000000));

    fixed_masters();
    s_dat_r = '0;
    #1;
    do_reset();
    foreach (tbl[i]) begin
      s_dat_r = 32'hD00D_0000 + 32'(i);
      drive(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack, tbl[i].err);
      chk($sformatf("vec%0d ctl", i),
          {gnt, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err},
          {tbl[i].g, tbl[i].scyc, tbl[i].sstb, tbl[i].a0, tbl[i].e0,
           tbl[i].a1, tbl[i].e1});
      chk($sformatf("vec%0d bus", i), {s_we, s_adr, s_sel, s_dat_w},
          bus_of(tbl[i].g));
      chk($sformatf("vec%0d dat_r", i), {m0_dat_r, m1_dat_r}, {2{s_dat_r}});
      tick();
    end

    // tie right after reset: m0 first, then m1 with no idle cycle
    do_reset();
    drive(1, 1, 1, 1, 0, 0);
    chk("tie idle gnt", {gnt, s_cyc}, 3'b000);
    tick();
    chk("tie first gnt", {gnt, s_cyc, s_adr}, {2'b01, 1'b1, 32'h100});
    drive(0, 0, 1, 1, 0, 0);
    chk("tie release gnt", gnt, 2'b01);
    tick();
    chk("tie handover gnt", {gnt, s_adr}, {2'b10, 32'h200});

    // both requesting continuously with one-beat transfers
    do_reset();
    acks = '{0, 0};
    drop = '{0, 0};
    done = 0;
    for (int c = 0; c < 60 && done < 8; c++) begin
      drive(!drop[0], !drop[0], !drop[1], !drop[1], 0, 0);
      s_ack = s_cyc & s_stb;
      #1;
      drop = '{0, 0};
      if (m0_ack | m1_ack) begin
        w = m1_ack ? 1 : 0;
        chk($sformatf("fair order %0d", done), w, done % 2);
        acks[w]++;
        drop[w] = 1'b1;
        done++;
      end
      tick();
    end
    chk("fair transfers", done, 8);
    chk("fair m0 count", acks[0], 4);
    chk("fair m1 count", acks[1], 4);

    // asynchronous reset mid-transfer of m1
    do_reset();
    drive(0, 0, 1, 1, 0, 0);
    tick();
    chk("rst pre gnt", {gnt, s_cyc}, 3'b101);
    s_ack = 1'b1;
    s_err = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("rst async ctl", {gnt, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err},
        8'h00);
    tick();
    tick();
    chk("rst held ctl", {gnt, s_cyc, m1_ack, m1_err}, 5'b0);
    reset = 1'b0;
    drive(1, 1, 1, 1, 0, 0);
    chk("rst after idle", gnt, 2'b00);
    tick();
    chk("rst after tie m0", gnt, 2'b01);

`ifdef WB_ARB_TIMEOUT_EN
    // stalled slave with m1 waiting
    do_reset();
    drive(1, 1, 1, 1, 0, 0);
    tick();
    for (int k = 1; k <= TO; k++) begin
      if (k < TO)
        chk($sformatf("to stall %0d", k), {gnt, m0_ack, m0_err, s_cyc, s_stb},
            6'b010011);
      else
        chk("to fire", {gnt, m0_ack, m0_err, s_cyc, s_stb}, 6'b010100);
      tick();
    end
    chk("to m1 granted", {gnt, m0_err}, 3'b100);
`endif

    // randomized traffic against the grant-owner model
    do_reset();
    own = -1; mlast = 1; mcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      m0_cyc   = m0_cyc ^ ($urandom_range(0, 3) == 0);
      m1_cyc   = m1_cyc ^ ($urandom_range(0, 3) == 0);
      m0_stb   = ($urandom_range(0, 3) != 0);
      m1_stb   = ($urandom_range(0, 3) != 0);
      m0_we    = 1'($urandom);
      m1_we    = 1'($urandom);
      m0_adr   = $urandom;
      m1_adr   = $urandom;
      m0_sel   = 4'($urandom);
      m1_sel   = 4'($urandom);
      m0_dat_w = $urandom;
      m1_dat_w = $urandom;
      s_dat_r  = $urandom;
      s_ack    = ($urandom_range(0, 2) == 0);
      s_err    = ($urandom_range(0, 15) == 0);
      #1;
      mc[0] = m0_cyc; mc[1] = m1_cyc;
      ms[0] = m0_stb; ms[1] = m1_stb;
      e_to = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      e_to = (own >= 0) && (mcnt == TO - 1);
`endif
      e_gnt = 2'b00; e_scyc = 1'b0; e_sstb = 1'b0;
      e_a0 = 1'b0; e_e0 = 1'b0; e_a1 = 1'b0; e_e1 = 1'b0;
      e_bus = '0;
      if (own == 0) begin
        e_gnt = 2'b01;
        e_scyc = m0_cyc & ~e_to; e_sstb = m0_stb & ~e_to;
        e_a0 = s_ack; e_e0 = s_err | e_to;
        e_bus = {m0_we, m0_adr, m0_sel, m0_dat_w};
      end else if (own == 1) begin
        e_gnt = 2'b10;
        e_scyc = m1_cyc & ~e_to; e_sstb = m1_stb & ~e_to;
        e_a1 = s_ack; e_e1 = s_err | e_to;
        e_bus = {m1_we, m1_adr, m1_sel, m1_dat_w};
      end
      chk($sformatf("rand%0d ctl", i),
          {gnt, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err},
          {e_gnt, e_scyc, e_sstb, e_a0, e_e0, e_a1, e_e1});
      chk($sformatf("rand%0d bus", i), {s_we, s_adr, s_sel, s_dat_w}, e_bus);
      chk($sformatf("rand%0d dat_r", i), {m0_dat_r, m1_dat_r}, {2{s_dat_r}});
      if (own < 0) begin
        if (mc[0] && mc[1]) nxt = 1 - mlast;
        else if (mc[0])     nxt = 0;
        else if (mc[1])     nxt = 1;
        else                nxt = -1;
      end else if (!mc[own] || e_to) begin
        nxt = mc[1 - own] ? 1 - own : -1;
      end else begin
        nxt = own;
      end
      if (nxt >= 0 && nxt != own) mcnt = 0;
      else if (own >= 0) begin
        if (s_ack || s_err || e_to) mcnt = 0;
        else if (mc[own] && ms[own]) mcnt++;
      end
      if (nxt >= 0) mlast = nxt;
      own = nxt;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_ddr_arbiter.md
Name: wb_ddr_arbiter

Overview:
Two-master Wishbone arbiter that shares the single DDR-controller slave port between the LM32 instruction bus (master 0) and the LM32 data bus (master 1). It sits between the CPU and the DDR controller. Grants are round-robin, and a grant is held for the whole bus cycle. It supplies combinational request/response muxing, so a granted transfer adds no wait states.

Parameters:
ADR_W, 32, address width of all ports
TIMEOUT, 1024, slave-stall cycles before a forced error (used only with WB_ARB_TIMEOUT_EN); must be >= 2

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
mN_cyc  input  1  master N (N=0,1) cycle / bus request
mN_stb  input  1  master N strobe
mN_we  input  1  master N write enable
mN_adr  input  ADR_W  master N address
mN_sel  input  4  master N byte selects
mN_dat_w  input  32  master N write data
mN_dat_r  output  32  read data to master N
mN_ack  output  1  acknowledge to master N
mN_err  output  1  error to master N
s_cyc  output  1  slave cycle
s_stb  output  1  slave strobe
s_we  output  1  slave write enable
s_adr  output  ADR_W  slave address
s_sel  output  4  slave byte selects
s_dat_w  output  32  slave write data
s_dat_r  input  32  slave read data
s_ack  input  1  slave acknowledge
s_err  input  1  slave error
gnt  output  2  one-hot current grant, for debug and LED monitoring

Behaviour:
- State: IDLE, GNT0, GNT1. Register last_gnt is 0 or 1.
- Reset is asynchronous and may arrive mid-operation:
  - state goes to IDLE and last_gnt to 1, so master 0 wins the first tie.
  - gnt=00. All s_* control outputs are 0. All mN_ack and mN_err are 0.
  - Any transfer in flight is abandoned; the slave sees s_cyc=0.
- In IDLE:
  - If exactly one mN_cyc is high, go to GNTN at the next edge.
  - If both are high, grant the master != last_gnt.
  - Arbitration latency is 1 cycle from cyc to s_cyc.
- Entering GNTN sets last_gnt=N.
- In GNTN:
  - s_cyc = mN_cyc and s_stb = mN_stb.
  - s_we, s_adr, s_sel, s_dat_w come from master N.
  - mN_ack = s_ack and mN_err = s_err.
  - The other master sees ack=0 and err=0.
  - Both mN_dat_r = s_dat_r (broadcast). This is legal because ack qualifies the data.
- In IDLE: s_cyc = s_stb = 0, s_we = 0, and the slave address, select and write-data outputs are don't-care, driven 0.
- Hold: the grant is held while mN_cyc=1, regardless of stb. This lets a master lock multi-beat sequences.
- Release, at the edge where the granted master's cyc is sampled 0:
  - If the other master's cyc is 1, go directly to its GNT state (no idle bubble).
  - Otherwise go to IDLE.
- A non-granted master that drops cyc before being granted is simply not granted; nothing is queued.
- Abort: if the granted master drops cyc with stb pending and no ack, the slave sees cyc=0 in that same cycle. Release follows the normal rule.
- s_ack and s_err arriving while in IDLE are ignored, never forwarded.
- Fairness: two continuously requesting masters alternate after each release. Neither waits more than one full cycle of the other.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entering a GNT state and whenever s_ack or s_err is seen.
  - It increments each cycle in which s_cyc & s_stb are high without ack or err.
  - When it reaches TIMEOUT-1, the granted mN_err pulses for exactly 1 cycle and s_cyc/s_stb are forced 0 that cycle.
  - At the following edge the state releases as if cyc had dropped.
  - The counter width is clog2(TIMEOUT).
- When undefined: no counter exists and a stalled slave holds the grant indefinitely.

Test Plan:
- Reset, then m0_cyc=stb=1 at adr 0x100 with s_ack returned after 3 cycles → s_cyc rises 1 cycle after m0_cyc, s_adr=0x100, m0_ack pulses once, m1_ack stays 0, gnt=01.
- Both cyc rise in the same cycle after reset → m0 is granted first; when m0 drops cyc, m1 is granted at the next edge with no IDLE cycle; gnt goes 01→10.
- Both requesters held continuously, each doing 1-beat transfers and releasing → grants alternate 0,1,0,1 for 8 transfers; each master completes 4.
- m1 granted and mid-transfer (stb=1, no ack), then reset pulsed for 2 cycles → asynchronously, s_cyc=0, gnt=00 and all ack/err=0; after release m0 wins the tie.
- m0 granted with s_err=1 returned → m0_err pulses once, m0_ack=0; an s_ack injected while in IDLE is not seen on m0_ack or m1_ack.
- With WB_ARB_TIMEOUT_EN, TIMEOUT=16 and the slave never acking → m0_err pulses at cycle 16 of the stall and s_cyc=0 that cycle; a pending m1 is granted next.
